// File: rtl/grad_disp_if.sv
// Handshake and data bundle for the disparity-window builder: pixel-pair
// input stream and flat left-window / delayed-right output stream.
interface grad_disp_if #(
    parameter int D = 256,
    parameter int W = 11
);
    logic           in_valid;
    logic           in_ready;
    logic           in_last;
    logic [W-1:0]   Ix_L_in;
    logic [W-1:0]   Iy_L_in;
    logic [W-1:0]   Ix_R_in;
    logic [W-1:0]   Iy_R_in;
    logic [D*W-1:0] Ix_L;
    logic [D*W-1:0] Iy_L;
    logic [W-1:0]   Ix_R;
    logic [W-1:0]   Iy_R;
    logic           out_valid;
    logic           out_last;

    modport master (
        output in_valid, in_last, Ix_L_in, Iy_L_in, Ix_R_in, Iy_R_in,
        input  in_ready, Ix_L, Iy_L, Ix_R, Iy_R, out_valid, out_last
    );

    modport slave (
        input  in_valid, in_last, Ix_L_in, Iy_L_in, Ix_R_in, Iy_R_in,
        output in_ready, Ix_L, Iy_L, Ix_R, Iy_R, out_valid, out_last
    );
endinterface

// File: rtl/grad_disp_window.sv
// Streaming disparity window: a D-deep left-gradient shift window plus a
// matching right-gradient delay, flushed with zeros at end of line.
module grad_disp_window #(
    parameter int D = 256,
    parameter int W = 11
) (
    input logic         clk,
    input logic         rst,
    input logic         clken,
    grad_disp_if.slave  bus
);

    localparam int              CW       = (D > 2) ? $clog2(D) : 1;
    localparam logic [0:0]      ST_RUN   = 1'b0;
    localparam logic [0:0]      ST_FLUSH = 1'b1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(D - 2);

    logic [0:0]     state_r;
    logic [CW-1:0]  cnt_r;
    logic [D*W-1:0] win_x_r;
    logic [D*W-1:0] win_y_r;
    logic [W-1:0]   rx_r [0:D-2];
    logic [W-1:0]   ry_r [0:D-2];
    logic [D-2:0]   rv_r;
    logic [D-2:0]   rl_r;
    logic [W-1:0]   ix_r_r;
    logic [W-1:0]   iy_r_r;
    logic           out_valid_r;
    logic           out_last_r;

    logic           in_ready_s;
    logic           accept_s;
    logic           flush_s;
    logic           shift_s;
    logic [W-1:0]   new_lx_s;
    logic [W-1:0]   new_ly_s;
    logic [W-1:0]   new_rx_s;
    logic [W-1:0]   new_ry_s;

    // Handshake decode and the sample injected on a shift (zeros while flushing).
    always_comb begin
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        flush_s    = 1'b0;
        new_lx_s   = {W{1'b0}};
        new_ly_s   = {W{1'b0}};
        new_rx_s   = {W{1'b0}};
        new_ry_s   = {W{1'b0}};
        if (state_r == ST_RUN) begin
            in_ready_s = ~rst;
            accept_s   = bus.in_valid & in_ready_s & clken;
        end else begin
            flush_s    = clken & ~rst;
        end
        if (accept_s) begin
            new_lx_s = bus.Ix_L_in;
            new_ly_s = bus.Iy_L_in;
            new_rx_s = bus.Ix_R_in;
            new_ry_s = bus.Iy_R_in;
        end else begin
            new_lx_s = {W{1'b0}};
            new_ly_s = {W{1'b0}};
            new_rx_s = {W{1'b0}};
            new_ry_s = {W{1'b0}};
        end
        shift_s = accept_s | flush_s;
    end

    // Line/flush sequencing: D-1 zero shifts after the last beat of a line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
            cnt_r   <= {CW{1'b0}};
        end else if (clken) begin
            case (state_r)
                ST_RUN: begin
                    if (accept_s && bus.in_last) begin
                        state_r <= ST_FLUSH;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_RUN;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    // Window and right-delay datapath; the output register is the last of D right stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_x_r     <= {(D*W){1'b0}};
            win_y_r     <= {(D*W){1'b0}};
            rv_r        <= {(D-1){1'b0}};
            rl_r        <= {(D-1){1'b0}};
            ix_r_r      <= {W{1'b0}};
            iy_r_r      <= {W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            for (int i = 0; i < D-1; i++) begin
                rx_r[i] <= {W{1'b0}};
                ry_r[i] <= {W{1'b0}};
            end
        end else if (shift_s) begin
            win_x_r     <= {new_lx_s, win_x_r[D*W-1:W]};
            win_y_r     <= {new_ly_s, win_y_r[D*W-1:W]};
            rx_r[0]     <= new_rx_s;
            ry_r[0]     <= new_ry_s;
            rv_r[0]     <= accept_s;
            rl_r[0]     <= accept_s & bus.in_last;
            for (int i = 1; i < D-1; i++) begin
                rx_r[i] <= rx_r[i-1];
                ry_r[i] <= ry_r[i-1];
                rv_r[i] <= rv_r[i-1];
                rl_r[i] <= rl_r[i-1];
            end
            ix_r_r      <= rx_r[D-2];
            iy_r_r      <= ry_r[D-2];
            out_valid_r <= rv_r[D-2];
            out_last_r  <= rv_r[D-2] & rl_r[D-2];
        end else if (clken) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
            out_last_r  <= out_last_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.Ix_L      = win_x_r;
    assign bus.Iy_L      = win_y_r;
    assign bus.Ix_R      = ix_r_r;
    assign bus.Iy_R      = iy_r_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_grad_disp_window.sv
// Bench for grad_disp_window: a D=4 instance checked every cycle against a
// per-line column model, plus a default D=256 instance for a long line.
module tb_grad_disp_window;

    localparam int DS = 4;
    localparam int DB = 256;
    localparam int W  = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clken_s = 1'b1;
    logic clken_b = 1'b1;

    always #5 clk = ~clk;

    grad_disp_if #(.D(DS), .W(W)) s_if ();
    grad_disp_if #(.D(DB), .W(W)) b_if ();

    grad_disp_window #(.D(DS), .W(W)) dut_s (.clk(clk), .rst(rst), .clken(clken_s), .bus(s_if.slave));
    grad_disp_window #(.D(DB), .W(W)) dut_b (.clk(clk), .rst(rst), .clken(clken_b), .bus(b_if.slave));

    // model of the current line of the small instance
    logic [W-1:0] m_lx[$];
    logic [W-1:0] m_ly[$];
    logic [W-1:0] m_rx[$];
    logic [W-1:0] m_ry[$];
    int           m_flush = 0;
    int           m_shift = 0;
    bit           m_ended = 1'b0;

    logic [DS*W-1:0] p_wx, p_wy;
    logic [W-1:0]    p_rx, p_ry;
    logic            p_v, p_l;

    int total = 0;
    int bad = 0;
    int big_pulses = 0;
    int big_lasts = 0;
    bit b_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_line();
        m_lx.delete(); m_ly.delete(); m_rx.delete(); m_ry.delete();
        m_shift = 0;
        m_ended = 1'b0;
    endtask

    task automatic set_in(input bit v, input bit last, input logic [W-1:0] lx, input logic [W-1:0] ly,
                          input logic [W-1:0] rx, input logic [W-1:0] ry);
        s_if.in_valid = v;
        s_if.in_last  = last;
        s_if.Ix_L_in  = lx;
        s_if.Iy_L_in  = ly;
        s_if.Ix_R_in  = rx;
        s_if.Iy_R_in  = ry;
    endtask

    task automatic set_idle();
        set_in(1'b0, 1'(($urandom & 1) != 0), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    // one clock: check in_ready before the edge, then outputs after it
    task automatic step(output bit acc);
        bit flsh, exp_rdy, lst;
        int c, idx;
        logic [W-1:0] lx, ly, rx, ry;
        logic [DS*W-1:0] ewx, ewy;
        #1;
        exp_rdy = !rst && (m_flush == 0);
        chk("in_ready", {63'd0, s_if.in_ready}, {63'd0, exp_rdy});
        acc  = clken_s && s_if.in_valid && exp_rdy;
        flsh = clken_s && !rst && (m_flush > 0);
        lst = s_if.in_last;
        lx = s_if.Ix_L_in; ly = s_if.Iy_L_in; rx = s_if.Ix_R_in; ry = s_if.Iy_R_in;
        b_rdy = b_if.in_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            m_flush = 0;
            clear_line();
            chk("rst_ix_l", 64'(s_if.Ix_L), 64'd0);
            chk("rst_iy_l", 64'(s_if.Iy_L), 64'd0);
            chk("rst_ix_r", 64'(s_if.Ix_R), 64'd0);
            chk("rst_iy_r", 64'(s_if.Iy_R), 64'd0);
            chk("rst_valid", {63'd0, s_if.out_valid}, 64'd0);
            chk("rst_last", {63'd0, s_if.out_last}, 64'd0);
        end else if (acc || flsh) begin
            if (acc) begin
                m_lx.push_back(lx); m_ly.push_back(ly); m_rx.push_back(rx); m_ry.push_back(ry);
                if (lst) begin
                    m_ended = 1'b1;
                    m_flush = DS - 1;
                end
            end else begin
                m_flush--;
            end
            if (m_shift >= DS - 1) begin
                c = m_shift - (DS - 1);
                for (int d = 0; d < DS; d++) begin
                    idx = c + d;
                    ewx[d*W +: W] = (idx < m_lx.size()) ? m_lx[idx] : {W{1'b0}};
                    ewy[d*W +: W] = (idx < m_ly.size()) ? m_ly[idx] : {W{1'b0}};
                end
                chk("win_x", 64'(s_if.Ix_L), 64'(ewx));
                chk("win_y", 64'(s_if.Iy_L), 64'(ewy));
                chk("ix_r", 64'(s_if.Ix_R), 64'(m_rx[c]));
                chk("iy_r", 64'(s_if.Iy_R), 64'(m_ry[c]));
                chk("out_valid", {63'd0, s_if.out_valid}, 64'd1);
                chk("out_last", {63'd0, s_if.out_last}, {63'd0, (m_ended && (c == m_lx.size() - 1))});
            end else begin
                chk("fill_valid", {63'd0, s_if.out_valid}, 64'd0);
                chk("fill_last", {63'd0, s_if.out_last}, 64'd0);
            end
            m_shift++;
            if (flsh && m_flush == 0) clear_line();
        end else begin
            chk("hold_win_x", 64'(s_if.Ix_L), 64'(p_wx));
            chk("hold_win_y", 64'(s_if.Iy_L), 64'(p_wy));
            chk("hold_ix_r", 64'(s_if.Ix_R), 64'(p_rx));
            chk("hold_iy_r", 64'(s_if.Iy_R), 64'(p_ry));
            if (clken_s) begin
                chk("idle_valid", {63'd0, s_if.out_valid}, 64'd0);
                chk("idle_last", {63'd0, s_if.out_last}, 64'd0);
            end else begin
                chk("stall_valid", {63'd0, s_if.out_valid}, {63'd0, p_v});
                chk("stall_last", {63'd0, s_if.out_last}, {63'd0, p_l});
            end
        end
        if (b_if.out_valid) begin
            big_pulses++;
            if (big_pulses == 1) begin
                chk("big_slot0_7ff", 64'(b_if.Ix_L[W-1:0]), 64'h7FF);
                chk("big_iy_r_400", 64'(b_if.Iy_R), 64'h400);
                chk("big_slot1_7ff", 64'(b_if.Ix_L[2*W-1:W]), 64'h7FF);
            end
            if (b_if.out_last) big_lasts++;
        end
        p_wx = s_if.Ix_L; p_wy = s_if.Iy_L; p_rx = s_if.Ix_R; p_ry = s_if.Iy_R;
        p_v = s_if.out_valid; p_l = s_if.out_last;
    endtask

    task automatic wait_flush();
        bit a;
        int guard;
        guard = 0;
        while (m_flush > 0 && guard < 200) begin
            set_idle();
            clken_s = 1'b1;
            step(a);
            guard++;
        end
        if (m_flush > 0) chk("flush_timeout", 64'd0, 64'd1);
    endtask

    // one line: gap idle cycles before each beat; optional random stalls
    task automatic send_line(input int len, input int gap, input bit rnd, input bit directed, input bit do_flush);
        bit a;
        int guard;
        for (int col = 0; col < len; col++) begin
            for (int g = 0; g < gap; g++) begin
                set_idle();
                clken_s = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                step(a);
            end
            a = 1'b0;
            guard = 0;
            while (!a && guard < 200) begin
                if (directed)
                    set_in(1'b1, col == len - 1, W'(col + 1), W'($urandom), W'(100 + col), W'($urandom));
                else
                    set_in(1'b1, col == len - 1, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
                clken_s = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                step(a);
                guard++;
            end
            if (!a) chk("accept_timeout", 64'd0, 64'd1);
        end
        set_idle();
        clken_s = 1'b1;
        if (do_flush) wait_flush();
    endtask

    initial begin
        bit a;
        int guard;
        b_if.in_valid = 1'b0; b_if.in_last = 1'b0;
        b_if.Ix_L_in = '0; b_if.Iy_L_in = '0; b_if.Ix_R_in = '0; b_if.Iy_R_in = '0;
        set_idle();

        // reset held 3 cycles with random inputs
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'($urandom), 1'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            step(a);
        end
        rst = 1'b0;
        set_idle();
        step(a);

        // continuous 8-pixel line, then the same data gapped
        send_line(8, 0, 1'b0, 1'b1, 1'b1);
        send_line(8, 2, 1'b0, 1'b1, 1'b1);

        // single-pixel line with clken low 5 cycles after the first flush shift
        send_line(1, 0, 1'b0, 1'b0, 1'b0);
        step(a);
        clken_s = 1'b0;
        for (int i = 0; i < 5; i++) step(a);
        clken_s = 1'b1;
        wait_flush();
        step(a);

        // reset pulsed mid-flush, then a fresh line
        send_line(5, 0, 1'b0, 1'b1, 1'b0);
        step(a);
        rst = 1'b1;
        step(a);
        rst = 1'b0;
        send_line(6, 0, 1'b0, 1'b1, 1'b1);

        // randomized lines with random gaps and stalls
        for (int l = 0; l < 8; l++)
            send_line($urandom_range(1, 10), $urandom_range(0, 2), 1'b1, 1'b0, 1'b1);
        step(a);

        // default-depth instance: 300-pixel line with extreme signed patterns
        for (int col = 0; col < 300; col++) begin
            b_if.in_valid = 1'b1;
            b_if.in_last  = (col == 299);
            b_if.Ix_L_in  = 11'h7FF;
            b_if.Iy_L_in  = W'($urandom);
            b_if.Ix_R_in  = W'($urandom);
            b_if.Iy_R_in  = 11'h400;
            guard = 0;
            do begin
                step(a);
                guard++;
            end while (!b_rdy && guard < 400);
            if (!b_rdy) chk("big_accept_timeout", 64'd0, 64'd1);
        end
        b_if.in_valid = 1'b0;
        b_if.in_last  = 1'b0;
        for (int i = 0; i < 270; i++) step(a);
        chk("big_pulse_count", 64'(big_pulses), 64'd300);
        chk("big_last_count", 64'(big_lasts), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
